// File: rtl/accel_seq_ctrl.sv
// Register-mapped sequencer driving an 8-bit datapath over req/ack.
// Issues COUNT operations and accumulates results into a 16-bit acc.
module accel_seq_ctrl #(
  parameter int         TIMEOUT = 16,
  parameter logic [1:0] OP_CODE = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  address,
  input  logic        data_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        dp_req,
  output logic [1:0]  dp_op,
  output logic [7:0]  dp_a,
  output logic [7:0]  dp_b,
  input  logic        dp_ack,
  input  logic [15:0] dp_result,
  output logic        user_interrupt,
  output logic [7:0]  uo_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  count;
  logic [7:0]  idx;
  logic [7:0]  timer;
  logic [15:0] acc;
  logic        busy;
  logic        done;
  logic        err;

  logic wr_ctrl;
  logic start;
  logic abort;
  logic clr;
  logic cfg_wr;

  assign wr_ctrl = data_write && (address == 4'd3);
  // ABORT dominates a START carried in the same write
  assign start   = wr_ctrl && data_in[0] && !data_in[1];
  assign abort   = wr_ctrl && data_in[1];
  assign clr     = wr_ctrl && data_in[2];
  assign cfg_wr  = data_write && !busy;

  assign dp_req = (state == REQ);
  assign dp_op  = OP_CODE;
  assign dp_a   = a;
  assign dp_b   = b + idx;

  assign user_interrupt = done | err;
  assign uo_out         = {5'b0, err, done, busy};

  always_comb begin
    data_out = 8'h00;
    unique case (1'b1)
      address == 4'd0: data_out = a;
      address == 4'd1: data_out = b;
      address == 4'd2: data_out = count;
      address == 4'd3: data_out = uo_out;
      address == 4'd4: data_out = acc[7:0];
      address == 4'd5: data_out = acc[15:8];
      address == 4'd6: data_out = idx;
      default:         data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      count <= '0;
      idx   <= '0;
      timer <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      state <= IDLE;
    end else begin
      if (cfg_wr) begin
        unique case (1'b1)
          address == 4'd0: a     <= data_in;
          address == 4'd1: b     <= data_in;
          address == 4'd2: count <= data_in;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (clr) begin
            done <= 1'b0;
            err  <= 1'b0;
          end
          if (start) begin
            acc <= '0;
            if (count != 8'd0) begin
              idx   <= '0;
              timer <= '0;
              done  <= 1'b0;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        REQ: begin
          if (dp_ack) begin
            acc   <= acc + dp_result;
            timer <= '0;
          end
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dp_ack) begin
            state <= STEP;
          end else if (timer == TLAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        STEP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx + 8'd1;
            if (idx + 8'd1 == count) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              timer <= '0;
              state <= REQ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
